// File: rtl/mem_dump_ctrl.sv
// Debug memory dump sequencer: walks the MEM-stage data memory word by word
// and streams each word LSB-first as four bytes through the UART TX handshake.
module mem_dump_ctrl #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_halted,
  output logic [31:0] o_mem_addr,
  input  logic [31:0] i_mem_data,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_start,
  input  logic        i_tx_done,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_abort
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_TX,
    S_NEXT,
    S_DONE
  } state_e;

  // Address of the last word in the memory (2^ADDR_WIDTH - 4).
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ~ADDR_WIDTH'(3);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [31:0]           word_q, word_d;
  logic                  abort_q, abort_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    addr_d     = addr_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    abort_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start && i_halted) begin
          addr_d     = '0;
          byte_idx_d = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        word_d  = i_mem_data;
        state_d = S_SEND;
      end
      S_SEND: state_d = S_WAIT_TX;
      S_WAIT_TX: begin
        if (i_tx_done) begin
          if (byte_idx_q == 2'd3) begin
            state_d = S_NEXT;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            word_d     = word_q >> 8;
            state_d    = S_SEND;
          end
        end
      end
      S_NEXT: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          addr_d     = addr_q + ADDR_WIDTH'(4);
          byte_idx_d = '0;
          state_d    = S_LOAD;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Losing the halt hands the memory port back to the pipeline; this wins over i_tx_done.
    if (state_q inside {S_LOAD, S_SEND, S_WAIT_TX, S_NEXT} && !i_halted) begin
      state_d = S_IDLE;
      abort_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      abort_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      addr_q     <= addr_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      abort_q    <= abort_d;
    end
  end

  assign o_busy     = (state_q != S_IDLE);
  assign o_mem_addr = o_busy ? 32'(addr_q) : 32'd0;
  assign o_tx_data  = o_busy ? word_q[7:0] : 8'd0;
  assign o_tx_start = (state_q == S_SEND);
  assign o_done     = (state_q == S_DONE);
  assign o_abort    = abort_q;

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Self-checking bench for mem_dump_ctrl: a behavioural UART responder and a
// memory model feed the DUT; the captured byte stream is compared to the memory image.
module tb_mem_dump_ctrl;

  localparam int NWORDS = 64;
  localparam int NBYTES = NWORDS * 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic        i_halted;
  logic [31:0] o_mem_addr;
  logic [31:0] i_mem_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_done;
  logic        o_busy;
  logic        o_done;
  logic        o_abort;

  logic [31:0] mem [NWORDS];
  logic        resp_done = 1'b0;
  logic        man_done  = 1'b0;
  int          fixed_lat = -1;
  int          cnt       = -1;
  int          cyc       = 0;
  int          last_txd  = 0;
  int          done_cyc  = 0;
  int          done_cnt  = 0;
  int          abort_cnt = 0;
  logic [7:0]  cap_byte [$];
  logic [31:0] cap_addr [$];

  int checks   = 0;
  int failures = 0;

  mem_dump_ctrl #(.ADDR_WIDTH(8)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_halted   (i_halted),
    .o_mem_addr (o_mem_addr),
    .i_mem_data (i_mem_data),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .i_tx_done  (i_tx_done),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_abort    (o_abort)
  );

  always #5 i_clk = ~i_clk;

  assign i_mem_data = mem[o_mem_addr[7:2]];
  assign i_tx_done  = resp_done | man_done;

  // UART responder and output monitor, both sampling mid-cycle.
  always @(negedge i_clk) begin
    cyc++;
    resp_done = 1'b0;
    if (i_reset || !i_halted) begin
      cnt = -1;
    end else if (cnt == 0) begin
      resp_done = 1'b1;
      cnt       = -1;
      last_txd  = cyc;
    end else if (cnt > 0) begin
      cnt--;
    end
    if (o_tx_start) begin
      cap_byte.push_back(o_tx_data);
      cap_addr.push_back(o_mem_addr);
      cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (o_abort) abort_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_dump();
    cap_byte.delete();
    cap_addr.delete();
    done_cnt  = 0;
    abort_cnt = 0;
    i_halted  = 1'b1;
    i_start   = 1'b1;
    tick();
    i_start = 1'b0;
    check("busy_after_start", 64'(o_busy), 64'd1);
    check("load_addr_zero", 64'(o_mem_addr), 64'd0);
  endtask

  task automatic wait_starts(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      tick();
      if (o_tx_start && cap_byte.size() == n - 1) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_starts_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_done(input bit hold_start);
    bit ok = 1'b0;
    for (int k = 0; k < 8000; k++) begin
      i_start = hold_start && (k < 60);
      tick();
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    i_start = 1'b0;
    check("wait_done_timeout", 64'(ok), 64'd1);
  endtask

  // Expected stream: every word in address order, each split LSB-first into bytes.
  task automatic check_stream();
    int bad_b = 0;
    int bad_a = 0;
    check("byte_count", 64'(cap_byte.size()), 64'(NBYTES));
    if (cap_byte.size() == NBYTES) begin
      for (int w = 0; w < NWORDS; w++) begin
        for (int k = 0; k < 4; k++) begin
          logic [7:0] eb;
          eb = 8'((mem[w] >> (8 * k)) & 32'hff);
          check($sformatf("byte_w%0d_b%0d", w, k), 64'(cap_byte[w*4+k]), 64'(eb));
          check($sformatf("addr_w%0d_b%0d", w, k), 64'(cap_addr[w*4+k]), 64'(w * 4));
        end
      end
    end
    tick();
    check("done_count", 64'(done_cnt), 64'd1);
    check("abort_none", 64'(abort_cnt), 64'd0);
    check("busy_low_after", 64'(o_busy), 64'd0);
    check("done_latency", 64'(done_cyc - last_txd), 64'd2);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    bit ok;
    int sz;

    i_reset  = 1'b1;
    i_start  = 1'b0;
    i_halted = 1'b0;
    for (int w = 0; w < NWORDS; w++) mem[w] = $urandom;
    idle(3);
    check("reset_outputs",
          {o_mem_addr, o_tx_data, o_tx_start, o_busy, o_done, o_abort},
          64'd0);
    i_reset = 1'b0;
    idle(2);

    // Start without halt is ignored.
    i_start  = 1'b1;
    i_halted = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("nohalt_busy", 64'(o_busy), 64'd0);
      check("nohalt_txstart", 64'(o_tx_start), 64'd0);
    end
    i_start = 1'b0;
    idle(2);

    // Known word at address 0, fixed UART latency.
    mem[0]    = 32'hA1B2C3D4;
    fixed_lat = 2;
    start_dump();
    wait_done(1'b0);
    if (cap_byte.size() >= 4) begin
      check("w0_byte0", 64'(cap_byte[0]), 64'hD4);
      check("w0_byte1", 64'(cap_byte[1]), 64'hC3);
      check("w0_byte2", 64'(cap_byte[2]), 64'hB2);
      check("w0_byte3", 64'(cap_byte[3]), 64'hA1);
    end
    check_stream();
    idle(10);

    // Patterned memory, random latency, i_start held during the dump.
    for (int w = 0; w < NWORDS; w++) mem[w] = 32'(w) * 32'h01010101;
    fixed_lat = -1;
    start_dump();
    wait_done(1'b1);
    check_stream();
    idle(10);

    // Zero-wait UART.
    for (int w = 0; w < NWORDS; w++) mem[w] = $urandom;
    fixed_lat = 0;
    start_dump();
    wait_done(1'b0);
    check_stream();
    idle(10);

    // Abort in WAIT_TX of byte 2 of word 5, together with a tx_done pulse.
    fixed_lat = 5;
    start_dump();
    wait_starts(5 * 4 + 3, ok);
    tick();
    check("abort_pre_wait_tx", 64'(o_busy & ~o_tx_start), 64'd1);
    i_halted = 1'b0;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    check("abort_pulse", 64'(o_abort), 64'd1);
    check("abort_busy_low", 64'(o_busy), 64'd0);
    check("abort_addr_zero", 64'(o_mem_addr), 64'd0);
    sz = cap_byte.size();
    idle(20);
    check("abort_single", 64'(abort_cnt), 64'd1);
    check("abort_no_more_tx", 64'(cap_byte.size()), 64'(sz));
    check("abort_no_done", 64'(done_cnt), 64'd0);
    idle(5);

    // Reset during SEND of word 10, then a clean restart.
    fixed_lat = -1;
    start_dump();
    wait_starts(10 * 4 + 1, ok);
    i_reset = 1'b1;
    tick();
    check("rst_mid_outputs",
          {o_mem_addr, o_tx_data, o_tx_start, o_busy, o_done, o_abort},
          64'd0);
    i_reset = 1'b0;
    idle(10);
    check("rst_mid_no_done", 64'(done_cnt), 64'd0);
    check("rst_mid_no_abort", 64'(abort_cnt), 64'd0);
    start_dump();
    wait_done(1'b0);
    check_stream();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_dump_ctrl.md
# mem_dump_ctrl

Debug-side sequencer that dumps the data memory of the MEM stage over the UART transmitter while the pipeline is halted. It drives the debug read address of the MEM stage, captures each 32-bit word from the asynchronous debug read port, and serialises it LSB-first as four bytes through a start/done handshake with the UART TX. It sits in the debug unit, between the MEM stage debug port and the shared UART TX.

## Interface
- ADDR_WIDTH, 8: data memory byte-address width. The dump covers addresses 0 .. 2^ADDR_WIDTH-4 in steps of 4.
- i_clk  in  1  system clock, all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  dump request; accepted only in IDLE with i_halted=1
- i_halted  in  1  pipeline halted; debug owns the memory port
- o_mem_addr  out  32  debug read address to the MEM stage; zero-extended word address
- i_mem_data  in  32  debug read data from the MEM stage; combinational from o_mem_addr, valid in the same cycle
- o_tx_data  out  8  byte to transmit
- o_tx_start  out  1  one-cycle pulse launching a UART byte
- i_tx_done  in  1  one-cycle pulse from the UART when a byte is finished
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse when the full dump is complete
- o_abort  out  1  one-cycle pulse when a dump is cancelled by i_halted falling

## Operation
- Registers:
  - addr (ADDR_WIDTH bits)
  - byte_idx (2 bits)
  - word shift register (32 bits)
  - state: IDLE, LOAD, SEND, WAIT_TX, NEXT, DONE
- IDLE: if i_start & i_halted, set addr←0 and byte_idx←0, go to LOAD. Otherwise stay. i_start is ignored in every other state.
- LOAD: o_mem_addr = addr. Set word←i_mem_data, go to SEND.
- SEND: o_tx_data = word[7:0] and o_tx_start=1 for exactly this cycle. Go to WAIT_TX.
- WAIT_TX: hold o_tx_data. On i_tx_done:
  - if byte_idx==3, go to NEXT;
  - otherwise byte_idx←byte_idx+1, word←word>>8, go to SEND.
  - i_tx_done is ignored outside WAIT_TX.
- NEXT:
  - if addr==2^ADDR_WIDTH-4, go to DONE;
  - otherwise addr←addr+4, byte_idx←0, go to LOAD.
  - addr never wraps.
- DONE: o_done=1 for this cycle, then go to IDLE.
- Abort: in any state other than IDLE or DONE, if i_halted==0, go to IDLE and pulse o_abort for one cycle. No further o_tx_start is issued. Abort takes priority over i_tx_done in the same cycle.
- o_mem_addr is {zeros, addr} while busy and 0 in IDLE.
- o_tx_data is word[7:0] while busy and 0 in IDLE.

## Timing
- Reset values:
  - state=IDLE, addr=0, byte_idx=0, word=0
  - o_mem_addr=0, o_tx_data=0
  - o_tx_start=0, o_busy=0, o_done=0, o_abort=0
- Reset mid-dump returns to IDLE on the next edge with no o_done or o_abort pulse.
- Start accepted at edge E0. LOAD is the cycle after E0. The first o_tx_start is high in the cycle after E0+1.
- Per byte: 1 SEND cycle plus the WAIT_TX cycles up to and including the cycle where i_tx_done is sampled.
- Per word: 1 LOAD + 4×(1 SEND + WAIT) + 1 NEXT.
- With ADDR_WIDTH=8:
  - 64 words and 256 o_tx_start pulses;
  - o_done arrives 2 cycles after the i_tx_done of the last byte.
- o_busy falls in the cycle after DONE or the abort edge.
- i_tx_done arriving in the cycle immediately after SEND (zero-wait UART) is legal and must advance correctly.

## Test plan
- Word at address 0 = 0xA1B2C3D4, i_tx_done returned 3 cycles after each o_tx_start:
  - bytes observed are D4, C3, B2, A1 in that order;
  - o_mem_addr=0 during LOAD.
- Full dump, ADDR_WIDTH=8, memory word n = n×0x01010101:
  - exactly 256 o_tx_start pulses;
  - o_mem_addr sequence 0, 4, …, 252;
  - one o_done;
  - o_busy low afterwards.
- i_start with i_halted=0 → no state change, o_busy stays 0. A second i_start while busy → ignored, sequence unchanged.
- Zero-latency UART (i_tx_done in the cycle after o_tx_start) → 256 bytes, correct order, no duplicate or skipped byte.
- Drop i_halted during WAIT_TX of byte 2 of word 5, together with an i_tx_done pulse:
  - o_abort is a single pulse;
  - no further o_tx_start;
  - o_busy falls;
  - o_mem_addr returns to 0.
- Assert i_reset during SEND of word 10:
  - all outputs are 0 next cycle with no o_done or o_abort;
  - a new i_start restarts the dump at address 0.
